base_clock_enable: RTL and testbench
====================================

BASE_CLOCK_ENABLE -- requirements
Module: base_clock_enable

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports CLK and RESET.
REQ-002 The block SHALL expose parameter RESET_HOLD, default 16: the number of EN_1M79 pulses for which SYS_RESET is held after RESET release; legal range 1..255.
REQ-003 The block SHALL have the following ports:
- CLK  in  1  base clock, 107.4 MHz (CLK_BASE domain)
- RESET  in  1  synchronous active-high reset, driven from negated CLK_BASE_READY already synchronised to CLK
- TURBO  in  1  request CPU enable at 7.16 MHz instead of 3.58 MHz
- PHASE  out  6  base-cycle phase counter, 0..59
- EN_21M  out  1  single-cycle enable at 21.48 MHz (every 5 cycles)
- EN_7M  out  1  single-cycle enable at 7.16 MHz (every 15 cycles)
- EN_3M58  out  1  single-cycle enable at 3.58 MHz (every 30 cycles)
- EN_1M79  out  1  single-cycle enable at 1.79 MHz (every 60 cycles)
- CPU_EN  out  1  CPU clock enable, selected from EN_3M58 or EN_7M
- TURBO_ACTIVE  out  1  current effective turbo state
- SYS_RESET  out  1  stretched, phase-aligned system reset

Function
REQ-004 PHASE SHALL increment by 1 each CLK while RESET is low, and SHALL wrap from 59 to 0; values 60..63 SHALL never occur.
REQ-005 All EN_* outputs SHALL be registered, and each SHALL be high exactly when PHASE holds the matching value:
- EN_21M: PHASE mod 5 = 4
- EN_7M: PHASE mod 15 = 14
- EN_3M58: PHASE mod 30 = 29
- EN_1M79: PHASE = 59
REQ-006 Each enable SHALL be exactly one CLK wide, and the spacing between enables SHALL be exact (5/15/30/60 cycles) with no jitter.
REQ-007 At PHASE = 59 all four enables SHALL assert together; they are coincident by design.
REQ-008 TURBO SHALL be sampled into an internal register only in the cycle PHASE = 59. The new value SHALL take effect from the PHASE = 0 cycle that follows; TURBO changes at any other phase SHALL have no effect until the next PHASE = 59.
REQ-009 CPU_EN SHALL equal EN_7M when the effective turbo state is 1, and EN_3M58 otherwise. No CPU_EN period SHALL be shorter than 15 cycles, and no period SHALL be longer than 30 cycles at a switch.
REQ-010 TURBO_ACTIVE SHALL equal the effective turbo state.
REQ-011 The hold counter SHALL count EN_1M79 pulses while SYS_RESET is high and RESET is low.
REQ-012 SYS_RESET SHALL fall in the cycle after the RESET_HOLD-th EN_1M79 pulse, so the first non-reset system cycle is always PHASE = 0.
REQ-013 SYS_RESET, once low, SHALL stay low until RESET asserts.

Reset
REQ-014 While RESET is high, the block SHALL hold the following values:
- PHASE = 0
- all EN_* = 0
- CPU_EN = 0
- effective turbo = 0, TURBO_ACTIVE = 0
- hold counter = 0
- SYS_RESET = 1
REQ-015 In the first cycle after RESET falls, PHASE SHALL be 0; EN_21M SHALL first assert at PHASE = 4 (the 5th cycle).
REQ-016 RESET asserted mid-operation SHALL take effect on the next CLK edge: it restarts the phase counter, reasserts SYS_RESET and restarts the hold count from 0. No partial enable pulse SHALL be emitted.

Configuration
REQ-017 Macro CLKEN_TURBO_EN SHALL control turbo support:
- Defined: the TURBO behaviour of REQ-008 to REQ-010 applies.
- Undefined: TURBO is ignored, CPU_EN = EN_3M58 permanently, TURBO_ACTIVE is tied 0, and the turbo sample register is not built. The port list is identical in both builds.

Structure
REQ-018 Package clock_enable_pkg SHALL hold:
- constants PHASE_LAST = 59, DIV_21M = 5, DIV_7M = 15, DIV_3M58 = 30, DIV_1M79 = 60
- typedef phase_t (6-bit)
REQ-019 The SYS_RESET hold counter SHALL be a sub-module, reset_stretch: inputs CLK, RESET, TICK (EN_1M79); output HOLD; parameter RESET_HOLD.

Verification
REQ-020 Reset release with TURBO = 0: PHASE counts 0,1,...,59,0; EN_21M is high at PHASE 4,9,...,59; EN_3M58 at 29 and 59; EN_1M79 only at 59; each pulse is 1 cycle wide.
REQ-021 RESET_HOLD = 16: SYS_RESET is high for exactly 960 cycles after RESET falls, and falls in the cycle PHASE = 0.
REQ-022 Turbo switch with CLKEN_TURBO_EN defined:
- TURBO 0->1 at PHASE = 10: CPU_EN stays on the 30-cycle spacing (pulse at 29), then pulses at 59, 14, 29, 44, 59; TURBO_ACTIVE rises at PHASE = 0.
- TURBO 1->0 at PHASE = 40: 15-cycle spacing continues until PHASE = 59, then 30-cycle spacing.
REQ-023 TURBO pulsed high only during PHASE 20..30 and low at PHASE = 59: TURBO_ACTIVE stays 0 and CPU_EN is unchanged.
REQ-024 RESET asserted at PHASE = 37 during the hold count: next cycle PHASE = 0, all EN = 0, SYS_RESET = 1; after release the full 960-cycle hold repeats.
REQ-025 Build without CLKEN_TURBO_EN, TURBO = 1 held: CPU_EN pulses every 30 cycles at PHASE 29 and 59; TURBO_ACTIVE = 0 throughout.

Source files
------------

// File: rtl/clock_enable_pkg.sv
// Shared constants and types for the base clock-enable generator.
// The 60-cycle phase frame of the 107.4 MHz base clock is divided into
// 21.48 / 7.16 / 3.58 / 1.79 MHz single-cycle enables.
package clock_enable_pkg;

    typedef logic [5:0] phase_t;

    localparam phase_t PHASE_LAST = 6'd59;
    localparam int     DIV_21M    = 5;
    localparam int     DIV_7M     = 15;
    localparam int     DIV_3M58   = 30;
    localparam int     DIV_1M79   = 60;

    // An enable with divider div fires on the last phase of each div-cycle slot,
    // so every divider lines up on PHASE_LAST.
    function automatic logic phase_hit(input phase_t ph, input int div);
        return (int'(ph) % div) == (div - 1);
    endfunction

endpackage

// File: rtl/base_clock_enable_reset_stretch.sv
// reset_stretch: holds the system reset high for RESET_HOLD ticks (EN_1M79
// pulses) after RESET is released. HOLD drops in the cycle after the final
// tick, which is always the start of a fresh phase frame.
module reset_stretch #(
    parameter int RESET_HOLD = 16   // legal range 1..255
) (
    input  logic CLK,
    input  logic RESET,
    input  logic TICK,
    output logic HOLD
);

    logic [7:0] cnt_q, cnt_d;
    logic       hold_q, hold_d;

    // Next-state: count ticks while holding; release on the last one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (hold_q && TICK) begin
            if (cnt_q == 8'(RESET_HOLD - 1)) begin
                hold_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset back into the hold state.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (RESET) begin
            cnt_q  <= 8'd0;
            hold_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign HOLD = hold_q;

endmodule

// File: rtl/base_clock_enable.sv
// base_clock_enable: 60-phase counter on the 107.4 MHz base clock producing
// registered single-cycle enables, the CPU enable and a stretched system reset.
// Build option: define CLKEN_TURBO_EN to let TURBO select a 7.16 MHz CPU
// enable; without it TURBO is ignored and the CPU always runs at 3.58 MHz.
module base_clock_enable
    import clock_enable_pkg::*;
#(
    parameter int RESET_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TURBO,
    output logic [5:0] PHASE,
    output logic       EN_21M,
    output logic       EN_7M,
    output logic       EN_3M58,
    output logic       EN_1M79,
    output logic       CPU_EN,
    output logic       TURBO_ACTIVE,
    output logic       SYS_RESET
);

    phase_t phase_q, phase_d;
    logic   en_21m_q, en_21m_d;
    logic   en_7m_q, en_7m_d;
    logic   en_3m58_q, en_3m58_d;
    logic   en_1m79_q, en_1m79_d;
    logic   cpu_en_q, cpu_en_d;

    // Enables are decoded from the next phase so the registered enable is
    // high in exactly the cycle PHASE holds the matching value.
    always_comb begin
        phase_d   = (phase_q == PHASE_LAST) ? '0 : phase_q + 6'd1;
        en_21m_d  = phase_hit(phase_d, DIV_21M);
        en_7m_d   = phase_hit(phase_d, DIV_7M);
        en_3m58_d = phase_hit(phase_d, DIV_3M58);
        en_1m79_d = phase_hit(phase_d, DIV_1M79);
    end

`ifdef CLKEN_TURBO_EN
    logic turbo_q, turbo_d;

    // TURBO is only looked at on the frame boundary so the CPU enable never
    // switches mid-frame; both enables coincide at PHASE_LAST.
    always_comb begin
        turbo_d  = (phase_q == PHASE_LAST) ? TURBO : turbo_q;
        cpu_en_d = turbo_d ? en_7m_d : en_3m58_d;
    end

    // Turbo sample register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            turbo_q <= 1'b0;
        end else begin
            turbo_q <= turbo_d;
        end
    end

    assign TURBO_ACTIVE = turbo_q;
`else
    logic unused_turbo;
    assign unused_turbo = TURBO;

    // Without turbo support the CPU enable is the 3.58 MHz enable.
    always_comb begin
        cpu_en_d = en_3m58_d;
    end

    assign TURBO_ACTIVE = 1'b0;
`endif

    // Phase counter and enable registers; reset clears every pulse at once.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q   <= '0;
            en_21m_q  <= 1'b0;
            en_7m_q   <= 1'b0;
            en_3m58_q <= 1'b0;
            en_1m79_q <= 1'b0;
            cpu_en_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            en_21m_q  <= en_21m_d;
            en_7m_q   <= en_7m_d;
            en_3m58_q <= en_3m58_d;
            en_1m79_q <= en_1m79_d;
            cpu_en_q  <= cpu_en_d;
        end
    end

    reset_stretch #(
        .RESET_HOLD(RESET_HOLD)
    ) u_reset_stretch (
        .CLK  (CLK),
        .RESET(RESET),
        .TICK (en_1m79_q),
        .HOLD (SYS_RESET)
    );

    assign PHASE   = phase_q;
    assign EN_21M  = en_21m_q;
    assign EN_7M   = en_7m_q;
    assign EN_3M58 = en_3m58_q;
    assign EN_1M79 = en_1m79_q;
    assign CPU_EN  = cpu_en_q;

endmodule

// File: tb/tb_base_clock_enable.sv
// Testbench for base_clock_enable: per-cycle scoreboard plus directed checks
// of reset stretch length, turbo switching and mid-hold reset.
module tb_base_clock_enable;

    localparam int HOLD = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       TURBO;
    logic [5:0] PHASE;
    logic       EN_21M, EN_7M, EN_3M58, EN_1M79;
    logic       CPU_EN, TURBO_ACTIVE, SYS_RESET;

    base_clock_enable #(
        .RESET_HOLD(HOLD)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .TURBO       (TURBO),
        .PHASE       (PHASE),
        .EN_21M      (EN_21M),
        .EN_7M       (EN_7M),
        .EN_3M58     (EN_3M58),
        .EN_1M79     (EN_1M79),
        .CPU_EN      (CPU_EN),
        .TURBO_ACTIVE(TURBO_ACTIVE),
        .SYS_RESET   (SYS_RESET)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0] phase;
        logic       en21;
        logic       en7;
        logic       en3;
        logic       en1;
        logic       cpu;
        logic       tact;
        logic       sys;
    } obs_t;

    obs_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural reference state
    int   m_phase = 0;
    int   m_cnt   = 0;
    logic m_turbo = 1'b0;
    logic m_sys   = 1'b1;

    int   got[$];
    int   n_hold;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every cycle's outputs with the queued expectation.
    always @(negedge CLK) begin
        obs_t e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {PHASE, EN_21M, EN_7M, EN_3M58, EN_1M79, CPU_EN, TURBO_ACTIVE, SYS_RESET};
            vectors++;
            if (a !== e) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL cycle_state @%0t: got ph=%0d en=%b cpu=%b ta=%b sys=%b expected ph=%0d en=%b cpu=%b ta=%b sys=%b",
                             $time, a.phase, {a.en21, a.en7, a.en3, a.en1}, a.cpu, a.tact, a.sys,
                             e.phase, {e.en21, e.en7, e.en3, e.en1}, e.cpu, e.tact, e.sys);
            end
        end
    end

    // Advance one clock, update the reference with the inputs seen at the edge,
    // and queue the expected outputs for that new cycle.
    task automatic step();
        logic e21, e7, e3, e1;
        @(posedge CLK);
        #1;
        if (RESET) begin
            m_phase = 0;
            m_turbo = 1'b0;
            m_cnt   = 0;
            m_sys   = 1'b1;
        end else begin
            if (m_sys && m_phase == 59) begin
                if (m_cnt == HOLD - 1) m_sys = 1'b0;
                else m_cnt++;
            end
`ifdef CLKEN_TURBO_EN
            if (m_phase == 59) m_turbo = TURBO;
`endif
            m_phase = (m_phase == 59) ? 0 : m_phase + 1;
        end
        e21 = (m_phase % 5) == 4;
        e7  = (m_phase % 15) == 14;
        e3  = (m_phase % 30) == 29;
        e1  = (m_phase == 59);
        sb_q.push_back({6'(m_phase), e21, e7, e3, e1, (m_turbo ? e7 : e3), m_turbo, m_sys});
    endtask

    task automatic step_to(input int p);
        int k = 0;
        while (m_phase != p && k < 70) begin
            step();
            k++;
        end
        check("step_to_reached", m_phase, p);
    endtask

    // Record the phases of the next n CPU_EN pulses (bounded).
    task automatic collect(input int n);
        int k = 0;
        got.delete();
        while (got.size() < n && k < 200) begin
            step();
            if (CPU_EN) got.push_back(int'(PHASE));
            k++;
        end
        check("cpu_pulse_count", got.size(), n);
    endtask

    task automatic compare_pulses(input string name, input int exp[]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check(name, got[i], exp[i]);
            else check(name, -1, exp[i]);
        end
    endtask

    // Count cycles SYS_RESET stays high after release (bounded).
    task automatic run_hold();
        n_hold = 0;
        while (SYS_RESET && n_hold < 2000) begin
            step();
            n_hold++;
        end
    endtask

    initial begin
        RESET = 1'b1;
        TURBO = 1'b0;
        repeat (3) step();
        check("reset_phase", int'(PHASE), 0);
        check("reset_sys_reset", int'(SYS_RESET), 1);
        check("reset_cpu_en", int'(CPU_EN), 0);

        // Release: 16 frames of held system reset, falling at phase 0
        RESET = 1'b0;
        run_hold();
        check("hold_len", n_hold, 960);
        check("hold_fall_phase", int'(PHASE), 0);
        repeat (60) step();

        // Turbo 0->1 at phase 10
        step_to(10);
        TURBO = 1'b1;
        collect(6);
`ifdef CLKEN_TURBO_EN
        compare_pulses("turbo_on_pulses", '{29, 59, 14, 29, 44, 59});
        check("turbo_active_on", int'(TURBO_ACTIVE), 1);
`else
        compare_pulses("turbo_on_pulses", '{29, 59, 29, 59, 29, 59});
        check("turbo_active_on", int'(TURBO_ACTIVE), 0);
`endif

        // Turbo 1->0 at phase 40
        step_to(40);
        TURBO = 1'b0;
        collect(4);
`ifdef CLKEN_TURBO_EN
        compare_pulses("turbo_off_pulses", '{44, 59, 29, 59});
`else
        compare_pulses("turbo_off_pulses", '{59, 29, 59, 29});
`endif
        check("turbo_active_off", int'(TURBO_ACTIVE), 0);

        // TURBO pulse confined to phases 20..30 is never sampled
        step_to(20);
        TURBO = 1'b1;
        step_to(31);
        TURBO = 1'b0;
        collect(4);
        compare_pulses("turbo_glitch_pulses", '{59, 29, 59, 29});
        check("turbo_glitch_active", int'(TURBO_ACTIVE), 0);

        // Reset mid-hold at phase 37
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        repeat (100) step();
        step_to(37);
        RESET = 1'b1;
        step();
        check("midreset_phase", int'(PHASE), 0);
        check("midreset_sys_reset", int'(SYS_RESET), 1);
        check("midreset_en", int'({EN_21M, EN_7M, EN_3M58, EN_1M79}), 0);
        RESET = 1'b0;
        run_hold();
        check("rehold_len", n_hold, 960);
        check("rehold_fall_phase", int'(PHASE), 0);

        // TURBO held high across frame boundaries
        TURBO = 1'b1;
        step_to(59);
        step();
        collect(2);
`ifdef CLKEN_TURBO_EN
        compare_pulses("turbo_held_pulses", '{14, 29});
        check("turbo_held_active", int'(TURBO_ACTIVE), 1);
`else
        compare_pulses("turbo_held_pulses", '{29, 59});
        check("turbo_held_active", int'(TURBO_ACTIVE), 0);
`endif
        repeat (60) step();

        @(negedge CLK);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
